mdc_reorder: RTL and testbench
==============================

MDC_REORDER -- requirements
Module: mdc_reorder

Interface
REQ-001 Parameter: N, default 16, points per frame, power of two, 4..64; LOG2N = log2(N).
REQ-002 CLK  input  1  sole clock, all state on rising edge.
REQ-003 RSTn  input  1  asynchronous active-low reset.
REQ-004 IN_VALID  input  1  D0/D1 carry one MDC output pair this cycle; no backpressure toward the FFT.
REQ-005 IN_SOF  input  1  qualifies IN_VALID: this pair is pair k=0 of a frame.
REQ-006 D0  input  64  complex sample, [63:32] real, [31:0] imag, two's complement.
REQ-007 D1  input  64  complex sample, same format as D0.
REQ-008 Q0  output  64  natural-order sample X[2m].
REQ-009 Q1  output  64  natural-order sample X[2m+1].
REQ-010 OUT_VALID  output  1  Q0/Q1 hold valid pair m.
REQ-011 OUT_READY  input  1  downstream accepts; handshake = OUT_VALID & OUT_READY.
REQ-012 OUT_LAST  output  1  high with pair m = N/2-1.
REQ-013 OVF  output  1  sticky: an input pair was dropped.

Function
REQ-014 Input pair k (k = 0..N/2-1) SHALL carry D0 = X[bitrev_LOG2N(2k)] and D1 = X[bitrev_LOG2N(2k)+N/2]; sample data SHALL be stored and output unmodified (no arithmetic).
REQ-015 Storage SHALL be two ping-pong banks of N x 64-bit registers, each with a FULL flag, plus write-bank pointer WB, read-bank pointer RB and pair counter K (LOG2N-1 bits).
REQ-016 An accepted pair SHALL write D0 to bank[WB][bitrev(2K)] and D1 to bank[WB][bitrev(2K)+N/2], then increment K.
REQ-017 IN_VALID & IN_SOF SHALL force K to 0 for that pair, discarding any partial frame in bank WB.
REQ-018 When pair K = N/2-1 is written: set FULL[WB], toggle WB, clear K.
REQ-019 Write-side states: RUN (accepting) and RESYNC (dropping until IN_SOF); reset state RUN.
REQ-020 IN_VALID while FULL[WB] = 1 SHALL drop the pair, set OVF, and enter RESYNC; in RESYNC, pairs without IN_SOF are dropped silently (no OVF); IN_SOF with FULL[WB] = 0 returns to RUN and is written as k=0.
REQ-021 Read FSM states: IDLE and SEND; IDLE -> SEND when FULL[RB] = 1, loading Q0/Q1 with pair m=0 on the next edge.
REQ-022 In SEND, Q0/Q1 SHALL be registered as bank[RB][2m], bank[RB][2m+1]; they SHALL hold stable while OUT_VALID & !OUT_READY.
REQ-023 On handshake with m < N/2-1, the next edge SHALL present pair m+1 (no bubble).
REQ-024 On handshake with m = N/2-1: clear FULL[RB], toggle RB; if the other bank is FULL, present its pair 0 on the next edge with OUT_VALID held high, else go to IDLE with OUT_VALID low.
REQ-025 Latency: frame's last pair accepted at edge t with read side IDLE -> OUT_VALID high, m=0, after edge t+1.
REQ-026 A FULL clear and a write into that same bank on the same edge SHALL both take effect; with OUT_READY held at 1, back-to-back frames SHALL never set OVF.

Reset
REQ-027 RSTn low SHALL asynchronously clear Q0, Q1, OUT_VALID, OUT_LAST, OVF, FULL[1:0], WB, RB, K, m, and set read FSM IDLE and write state RUN; bank contents need no reset.
REQ-028 Reset mid-frame or mid-output SHALL discard all buffered data; the first pair after release is treated as k=0.
REQ-029 OVF SHALL clear only on reset.

Structure
REQ-030 A shared package SHALL hold the complex word width (64), the default N, and the LOG2N-bit bitrev function.
REQ-031 One sub-module mdc_reorder_bank (N x 64 registers, two write and two read ports) SHALL be instantiated twice.

Verification
REQ-032 N=16, one frame, D0/D1 = {index, ~index} per REQ-014 (D0 order 0,4,2,6,1,5,3,7; D1 = D0+8), OUT_READY=1 -> 8 pairs (0,1),(2,3)..(14,15), first pair after edge t+1, OUT_LAST on the 8th.
REQ-033 Four back-to-back frames, OUT_READY=1 -> 32 contiguous output pairs, OVF=0.
REQ-034 OUT_READY toggling 1,0,0,1... -> Q0/Q1 stable during stalls, no pair lost or repeated.
REQ-035 OUT_READY=0 while three frames arrive -> frames 1 and 2 buffered, first pair of frame 3 dropped, OVF=1; later frames resume only after an IN_SOF pair arrives with a free bank.
REQ-036 IN_SOF at k=5 of a frame -> partial frame discarded, new frame output complete and correct.
REQ-037 RSTn pulsed low mid-output -> all outputs 0 immediately; next frame output correctly.

Source files
------------

// File: rtl/mdc_reorder_pkg.sv
// Shared types and helpers for the MDC output reorder buffer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package mdc_reorder_pkg;

  localparam int CW    = 64;  // complex word width: [63:32] real, [31:0] imag
  localparam int N_DEF = 16;  // default points per frame
  localparam int BR_W  = 6;   // widest index supported (N up to 64)

  typedef struct packed {
    logic [CW/2-1:0] re;
    logic [CW/2-1:0] im;
  } cplx_t;

  typedef enum logic {WR_RUN, WR_RESYNC} wr_state_e;
  typedef enum logic {RD_IDLE, RD_SEND}  rd_state_e;

  // Reverse the low lg bits of v; bits above lg come back as zero.
  function automatic logic [BR_W-1:0] bitrev(input logic [BR_W-1:0] v, input int lg);
    logic [BR_W-1:0] r;
    r = '0;
    for (int i = 0; i < BR_W; i++) begin
      if (i < lg) r = (r << 1) | BR_W'((v >> i) & 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/mdc_reorder_bank.sv
// One N-entry sample bank: two write ports sharing an enable, two async read ports.
// Latency: writes visible on the edge after we; reads are combinational.
// Backpressure: none; the owner decides when the bank may be written.
module mdc_reorder_bank
  import mdc_reorder_pkg::*;
#(
  parameter int N = N_DEF,
  localparam int AW = $clog2(N)
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] wa0,
  input  logic [AW-1:0] wa1,
  input  cplx_t         wd0,
  input  cplx_t         wd1,
  input  logic [AW-1:0] ra0,
  input  logic [AW-1:0] ra1,
  output cplx_t         rd0,
  output cplx_t         rd1
);

  cplx_t mem_q [N];
  cplx_t mem_d [N];

  // Both halves of an MDC pair land in the same edge; the two addresses never collide.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[wa0] = wd0;
      mem_d[wa1] = wd1;
    end
  end

  // Sample storage carries no reset: FULL flags decide what is meaningful.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign rd0 = mem_q[ra0];
  assign rd1 = mem_q[ra1];

endmodule

// File: rtl/mdc_reorder.sv
// Reorders bit-reversed MDC FFT output pairs into natural-order pairs via ping-pong banks.
// Latency: last pair of a frame written at edge t -> first output pair valid after edge t+1.
// Backpressure: OUT_READY stalls the read side; input is never stalled, overflow drops and sets OVF.
module mdc_reorder
  import mdc_reorder_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          IN_VALID,
  input  logic          IN_SOF,
  input  logic [CW-1:0] D0,
  input  logic [CW-1:0] D1,
  output logic [CW-1:0] Q0,
  output logic [CW-1:0] Q1,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic          OUT_LAST,
  output logic          OVF
);

  localparam int LOG2N = $clog2(N);
  localparam int KW    = LOG2N - 1;
  localparam logic [KW-1:0] K_LAST = KW'(N/2 - 1);

  wr_state_e       wr_st_q, wr_st_d;
  rd_state_e       rd_st_q, rd_st_d;
  logic [1:0]      full_q, full_d;
  logic            wb_q, wb_d;
  logic            rb_q, rb_d;
  logic [KW-1:0]   k_q, k_d;
  logic [KW-1:0]   m_q, m_d;
  logic [CW-1:0]   q0_q, q0_d;
  logic [CW-1:0]   q1_q, q1_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic            ovf_q, ovf_d;

  logic            wr_en, set_full, clr_full, free_wb;
  logic [KW-1:0]   k_w;
  logic [LOG2N-1:0] wa0, wa1, ra0, ra1;
  logic            load, rd_bank;
  logic [KW-1:0]   rd_m, m_inc;
  cplx_t           b_rd0 [2];
  cplx_t           b_rd1 [2];

  // Read side: walk pairs of bank RB, hop to the other bank without a bubble when it is ready.
  always_comb begin
    rd_st_d     = rd_st_q;
    rb_d        = rb_q;
    m_d         = m_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    load        = 1'b0;
    rd_bank     = rb_q;
    rd_m        = m_q;
    clr_full    = 1'b0;
    m_inc       = m_q + 1'b1;
    case (rd_st_q)
      RD_IDLE: begin
        if (full_q[rb_q]) begin
          load        = 1'b1;
          rd_m        = '0;
          m_d         = '0;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          rd_st_d     = RD_SEND;
        end
      end
      RD_SEND: begin
        if (out_valid_q && OUT_READY) begin
          if (m_q != K_LAST) begin
            load       = 1'b1;
            rd_m       = m_inc;
            m_d        = m_inc;
            out_last_d = (m_inc == K_LAST);
          end else begin
            clr_full   = 1'b1;
            rb_d       = ~rb_q;
            m_d        = '0;
            out_last_d = 1'b0;
            if (full_q[~rb_q]) begin
              load    = 1'b1;
              rd_bank = ~rb_q;
              rd_m    = '0;
            end else begin
              out_valid_d = 1'b0;
              rd_st_d     = RD_IDLE;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Write side: a bank being released this edge counts as free, so back-to-back frames never overflow.
  always_comb begin
    wr_st_d  = wr_st_q;
    k_d      = k_q;
    wb_d     = wb_q;
    ovf_d    = ovf_q;
    wr_en    = 1'b0;
    set_full = 1'b0;
    k_w      = IN_SOF ? '0 : k_q;
    free_wb  = !full_q[wb_q] || (clr_full && (rb_q == wb_q));
    if (IN_VALID) begin
      if (!free_wb) begin
        ovf_d   = 1'b1;
        wr_st_d = WR_RESYNC;
      end else if ((wr_st_q == WR_RUN) || IN_SOF) begin
        wr_en   = 1'b1;
        wr_st_d = WR_RUN;
        if (k_w == K_LAST) begin
          set_full = 1'b1;
          wb_d     = ~wb_q;
          k_d      = '0;
        end else begin
          k_d = k_w + 1'b1;
        end
      end
    end
  end

  // Release and fill can hit the same bank flag on one edge; the fill wins.
  always_comb begin
    full_d = full_q;
    if (clr_full) full_d[rb_q] = 1'b0;
    if (set_full) full_d[wb_q] = 1'b1;
  end

  // Output registers reload only when a new pair is due, otherwise they hold.
  always_comb begin
    q0_d = load ? b_rd0[rd_bank] : q0_q;
    q1_d = load ? b_rd1[rd_bank] : q1_q;
  end

  // Pair k scatters to bitrev(2k) and its partner N/2 above; pair m reads 2m and 2m+1.
  assign wa0 = LOG2N'(bitrev(BR_W'({k_w, 1'b0}), LOG2N));
  assign wa1 = wa0 + LOG2N'(N/2);
  assign ra0 = {rd_m, 1'b0};
  assign ra1 = {rd_m, 1'b1};

  for (genvar g = 0; g < 2; g++) begin : g_bank
    mdc_reorder_bank #(.N(N)) u_bank (
      .CLK (CLK),
      .we  (wr_en && (wb_q == 1'(g))),
      .wa0 (wa0),
      .wa1 (wa1),
      .wd0 (D0),
      .wd1 (D1),
      .ra0 (ra0),
      .ra1 (ra1),
      .rd0 (b_rd0[g]),
      .rd1 (b_rd1[g])
    );
  end

  // All control and output state; reset drops any buffered frames.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_st_q     <= WR_RUN;
      rd_st_q     <= RD_IDLE;
      full_q      <= '0;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      k_q         <= '0;
      m_q         <= '0;
      q0_q        <= '0;
      q1_q        <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      wr_st_q     <= wr_st_d;
      rd_st_q     <= rd_st_d;
      full_q      <= full_d;
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      k_q         <= k_d;
      m_q         <= m_d;
      q0_q        <= q0_d;
      q1_q        <= q1_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      ovf_q       <= ovf_d;
    end
  end

  assign Q0        = q0_q;
  assign Q1        = q1_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_LAST  = out_last_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_mdc_reorder.sv
// Scoreboard bench for mdc_reorder with N=16 and directed frames.
// Latency: expected pairs queued at stimulus time, popped by a monitor on each handshake.
// Backpressure: OUT_READY driven held high, held low, or toggling 1,0,0.
module tb_mdc_reorder;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        IN_VALID, IN_SOF, OUT_READY;
  logic [63:0] D0, D1, Q0, Q1;
  logic        OUT_VALID, OUT_LAST, OVF;

  always #5 CLK = ~CLK;

  mdc_reorder #(.N(16)) dut (
    .CLK(CLK), .RSTn(RSTn), .IN_VALID(IN_VALID), .IN_SOF(IN_SOF),
    .D0(D0), .D1(D1), .Q0(Q0), .Q1(Q1), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT_LAST(OUT_LAST), .OVF(OVF)
  );

  typedef struct packed {
    logic [63:0] q0;
    logic [63:0] q1;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   rdy_mode = 1;  // 0: ready low, 1: ready high, 2: pattern 1,0,0
  int   br [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  function automatic logic [63:0] xs(input int f, input int n);
    logic [31:0] r;
    r = 32'(f * 256 + n);
    return {r, ~r};
  endfunction

  function void chk_w(input string name, input logic [128:0] act, input logic [128:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endfunction

  function void chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_pair(input logic [63:0] d0, input logic [63:0] d1, input logic sof);
    IN_VALID = 1'b1;
    IN_SOF   = sof;
    D0       = d0;
    D1       = d1;
    tick();
  endtask

  // np pairs of frame f in MDC order; push queues the natural-order result.
  task automatic send_frame(input int f, input int np, input bit push, input bit sof0);
    if (push) begin
      for (int m = 0; m < 8; m++)
        sb.push_back('{q0: xs(f, 2*m), q1: xs(f, 2*m+1), last: (m == 7)});
    end
    for (int k = 0; k < np; k++)
      send_pair(xs(f, br[k]), xs(f, br[k] + 8), (k == 0) && sof0);
  endtask

  task automatic idle();
    IN_VALID = 1'b0;
    IN_SOF   = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while ((sb.size() != 0 || OUT_VALID) && n < bound) begin
      tick();
      n++;
    end
    chk_b("drain_queue_empty", sb.size() == 0, 1'b1);
    chk_b("drain_valid_low", OUT_VALID, 1'b0);
  endtask

  task automatic chk_zero();
    chk_w("rst_q0", 129'(Q0), 129'(0));
    chk_w("rst_q1", 129'(Q1), 129'(0));
    chk_b("rst_valid", OUT_VALID, 1'b0);
    chk_b("rst_last", OUT_LAST, 1'b0);
    chk_b("rst_ovf", OVF, 1'b0);
  endtask

  // Ready driver, changes just after each rising edge.
  initial begin : ready_drv
    int cyc = 0;
    OUT_READY = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      if (rdy_mode == 2) OUT_READY = (cyc % 3 == 0);
      else               OUT_READY = (rdy_mode == 1);
    end
  end

  // Monitor: compares every handshake against the scoreboard and checks holds during stalls.
  initial begin : monitor
    exp_t        e;
    logic        hold_vld;
    logic [63:0] h0, h1;
    hold_vld = 1'b0;
    h0 = '0;
    h1 = '0;
    forever begin
      @(negedge CLK);
      if (!RSTn) begin
        hold_vld = 1'b0;
      end else begin
        if (hold_vld) begin
          chk_b("stall_valid_held", OUT_VALID, 1'b1);
          chk_w("stall_q0_held", 129'(Q0), 129'(h0));
          chk_w("stall_q1_held", 129'(Q1), 129'(h1));
        end
        if (OUT_VALID && OUT_READY) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got pair %h %h, want no output", Q0, Q1);
          end else begin
            e = sb.pop_front();
            chk_w("out_pair", {Q0, Q1, OUT_LAST}, e);
          end
        end
        hold_vld = OUT_VALID && !OUT_READY;
        h0 = Q0;
        h1 = Q1;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    RSTn = 1'b0;
    IN_VALID = 1'b0;
    IN_SOF = 1'b0;
    D0 = '0;
    D1 = '0;
    rdy_mode = 1;
    repeat (3) @(posedge CLK);
    #1;
    chk_zero();
    RSTn = 1'b1;
    tick();

    // Single frame: latency and natural order.
    send_frame(1, 8, 1, 1);
    idle();
    chk_b("lat_t_valid_low", OUT_VALID, 1'b0);
    tick();
    chk_b("lat_t1_valid_high", OUT_VALID, 1'b1);
    chk_w("lat_t1_q0", 129'(Q0), 129'(xs(1, 0)));
    chk_w("lat_t1_q1", 129'(Q1), 129'(xs(1, 1)));
    wait_drain(40);

    // Four back-to-back frames: 32 pairs without bubbles, last handshake 33 edges after first frame ends.
    for (int f = 2; f < 6; f++) send_frame(f, 8, 1, 1);
    idle();
    repeat (8) tick();
    chk_b("b2b_tail_valid", OUT_VALID, 1'b1);
    chk_b("b2b_tail_last", OUT_LAST, 1'b1);
    tick();
    chk_b("b2b_end_valid", OUT_VALID, 1'b0);
    chk_b("b2b_queue_empty", sb.size() == 0, 1'b1);
    chk_b("b2b_ovf", OVF, 1'b0);

    // Ready toggling 1,0,0.
    rdy_mode = 2;
    send_frame(6, 8, 1, 1);
    send_frame(7, 8, 1, 1);
    idle();
    wait_drain(200);
    rdy_mode = 1;
    tick();

    // Overflow: two frames buffered, third dropped.
    rdy_mode = 0;
    tick();
    send_frame(10, 8, 1, 1);
    send_frame(11, 8, 1, 1);
    chk_b("ovf_before_third", OVF, 1'b0);
    send_frame(12, 8, 0, 1);
    idle();
    chk_b("ovf_set", OVF, 1'b1);
    chk_w("ovf_stalled_q0", 129'(Q0), 129'(xs(10, 0)));
    rdy_mode = 1;
    wait_drain(100);
    // Non-SOF pairs with free banks stay dropped while resynchronising.
    send_frame(40, 8, 0, 0);
    idle();
    repeat (4) tick();
    chk_b("resync_quiet", OUT_VALID, 1'b0);
    send_frame(13, 8, 1, 1);
    idle();
    wait_drain(60);
    chk_b("ovf_sticky", OVF, 1'b1);

    // SOF at k=5 abandons the partial frame.
    send_frame(20, 5, 0, 1);
    send_frame(21, 8, 1, 1);
    idle();
    wait_drain(60);

    // Reset during output, then a frame whose first pair has no SOF.
    send_frame(30, 8, 1, 1);
    send_frame(31, 8, 1, 1);
    idle();
    repeat (4) tick();
    chk_b("pre_rst_valid", OUT_VALID, 1'b1);
    RSTn = 1'b0;
    #1;
    chk_zero();
    sb.delete();
    repeat (2) tick();
    RSTn = 1'b1;
    tick();
    send_frame(32, 8, 1, 0);
    idle();
    wait_drain(60);
    chk_b("post_rst_ovf", OVF, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
